// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - 3-bit mdop encodings presented by the E stage
//   - FSM state type
//   - default busy-cycle counts for mult and div
package mdu_pkg;

    localparam logic [2:0] MDOP_MULT  = 3'd0;
    localparam logic [2:0] MDOP_MULTU = 3'd1;
    localparam logic [2:0] MDOP_DIV   = 3'd2;
    localparam logic [2:0] MDOP_DIVU  = 3'd3;
    localparam logic [2:0] MDOP_MTHI  = 3'd4;
    localparam logic [2:0] MDOP_MTLO  = 3'd5;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // Ops that occupy the unit for multiple cycles (mult/multu/div/divu)
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
               (op == MDOP_DIV)  || (op == MDOP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath of the multiply/divide unit.
// Ports:
//   op          latched mdop (only mult/multu/div/divu are meaningful)
//   a, b        latched rs / rt operands
//   result      {hi, lo}: product, or {remainder, quotient} for divides
//   div_by_zero high for div/divu with a zero divisor
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Low 64 bits of the product of sign-extended operands is the signed product
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'h0, a} * {32'h0, b};

    // Signed divide is done on magnitudes and the signs are reapplied, which
    // keeps 0x80000000 / -1 well defined (magnitude 2^31 negates to itself).
    always_comb begin
        a_neg       = (op == MDOP_DIV) && a[31];
        b_neg       = (op == MDOP_DIV) && b[31];
        mag_a       = a_neg ? (32'h0 - a) : a;
        mag_b       = b_neg ? (32'h0 - b) : b;
        div_by_zero = is_div_op(op) && (b == '0);
        // Zero divisor result is discarded; substitute 1 to keep the value defined
        div_b       = (mag_b == '0) ? 32'd1 : mag_b;
        quo         = mag_a / div_b;
        rem         = mag_a % div_b;
        quo_fix     = (a_neg ^ b_neg) ? (32'h0 - quo) : quo;
        rem_fix     = a_neg ? (32'h0 - rem) : rem;

        result = '0;
        case (op)
            MDOP_MULT:  result = prod_s;
            MDOP_MULTU: result = prod_u;
            MDOP_DIV,
            MDOP_DIVU:  result = {rem_fix, quo_fix};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit with architectural HI/LO registers (E stage).
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   start       E-stage instruction is an MDU op
//   mdop        0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   rs_val      dividend / multiplicand / mthi-mtlo source
//   rt_val      divisor / multiplier
//   hilo_sel    0 reads LO, 1 reads HI on hilo_out
//   busy        multi-cycle op in flight (registered)
//   hilo_out    combinational read of the selected HI/LO register
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] hilo_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    mdu_state_t    state;
    mdu_state_t    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   hi;
    logic [31:0]   lo;

    logic          latch;
    logic          wr_res;
    logic          wr_hi;
    logic          wr_lo;
    logic [63:0]   arith_res;
    logic          div_by_zero;

    mdu_arith u_arith (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .result      (arith_res),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        wr_res  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(mdop)) begin
                        state_n = ST_RUN;
                        latch   = 1'b1;
                        cnt_n   = is_div_op(mdop) ? DIV_LOAD : MULT_LOAD;
                    end else if (mdop == MDOP_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (mdop == MDOP_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at while running
                if (cnt == CNT_ONE) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    wr_res  = !div_by_zero;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (latch) begin
                op_q <= mdop;
                a_q  <= rs_val;
                b_q  <= rt_val;
            end
            if (wr_res) begin
                hi <= arith_res[63:32];
                lo <= arith_res[31:0];
            end else if (wr_hi) begin
                hi <= rs_val;
            end else if (wr_lo) begin
                lo <= rs_val;
            end
        end
    end

    assign busy     = (state == ST_RUN);
    assign hilo_out = hilo_sel ? hi : lo;

endmodule
